// File: rtl/debounce_multi.sv
// N-channel debouncer: per-channel synchroniser, LOW/WAIT_H/HIGH/WAIT_L FSM and down-counter
// producing a debounced level plus press/release ticks. Define DEBOUNCE_REPEAT_EN for auto-repeat.
module debounce_multi #(
    parameter int unsigned NCH           = 4,
    parameter int unsigned N             = 22,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic           clk_100MHz,
    input  logic           reset,
    input  logic [NCH-1:0] btn,
    output logic [NCH-1:0] db_level,
    output logic [NCH-1:0] press_tick,
    output logic [NCH-1:0] release_tick,
    output logic           press_any
);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_WAIT_H = 2'd1,
        ST_HIGH   = 2'd2,
        ST_WAIT_L = 2'd3
    } state_e;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
`endif

    if (NCH < 1 || NCH > 32 || N < 2 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("debounce_multi: parameter out of range");
    end

    logic [NCH-1:0] lvl_nxt;
    logic [NCH-1:0] press_nxt;
    logic [NCH-1:0] rel_nxt;

    logic [NCH-1:0] db_level_q;
    logic [NCH-1:0] press_tick_q;
    logic [NCH-1:0] release_tick_q;
    logic           press_any_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_e                 state_q, state_d;
        logic [N-1:0]           cnt_q, cnt_d;
        logic                   press_d;
        logic                   rel_d;

        always_ff @(posedge clk_100MHz or posedge reset) begin
            if (reset) begin
                sync_q  <= '0;
                state_q <= ST_LOW;
                cnt_q   <= '0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], btn[i]};
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        // Counter loads 2^N-1 on the first sample of the new level, so the transition
        // is confirmed on the 2^N-th consecutive sample (counter==1).
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                ST_LOW: begin
                    if (s) begin
                        state_d = ST_WAIT_H;
                        cnt_d   = '1;
                    end
                end
                ST_WAIT_H: begin
                    if (!s) begin
                        state_d = ST_LOW;
                    end else if (cnt_q == N'(1)) begin
                        state_d = ST_HIGH;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - N'(1);
                    end
                end
                ST_HIGH: begin
                    if (!s) begin
                        state_d = ST_WAIT_L;
                        cnt_d   = '1;
                    end
                end
                ST_WAIT_L: begin
                    if (s) begin
                        state_d = ST_HIGH;
                    end else if (cnt_q == N'(1)) begin
                        state_d = ST_LOW;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - N'(1);
                    end
                end
                default: state_d = ST_LOW;
            endcase
        end

        assign lvl_nxt[i] = (state_d == ST_HIGH) || (state_d == ST_WAIT_L);
        assign rel_nxt[i] = rel_d;

`ifdef DEBOUNCE_REPEAT_EN
        logic [RPT_W-1:0] rpt_q, rpt_d;
        logic             rpt_tick;

        always_ff @(posedge clk_100MHz or posedge reset) begin
            if (reset) rpt_q <= '0;
            else       rpt_q <= rpt_d;
        end

        // Runs only while HIGH, freezes across WAIT_L bounces, re-arms on each fresh press.
        always_comb begin
            rpt_d    = rpt_q;
            rpt_tick = 1'b0;
            case (state_q)
                ST_LOW: rpt_d = '0;
                ST_HIGH: begin
                    if (rpt_q == '0) begin
                        rpt_tick = 1'b1;
                        rpt_d    = RPT_W'(REPEAT_PERIOD - 1);
                    end else begin
                        rpt_d = rpt_q - RPT_W'(1);
                    end
                end
                default: rpt_d = rpt_q;
            endcase
            if (press_d) rpt_d = RPT_W'(REPEAT_DELAY - 1);
        end

        assign press_nxt[i] = press_d | rpt_tick;
`else
        assign press_nxt[i] = press_d;
`endif
    end

    // Outputs registered from next-state decode so ticks land in the first cycle of the new state.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            db_level_q     <= '0;
            press_tick_q   <= '0;
            release_tick_q <= '0;
            press_any_q    <= 1'b0;
        end else begin
            db_level_q     <= lvl_nxt;
            press_tick_q   <= press_nxt;
            release_tick_q <= rel_nxt;
            press_any_q    <= |press_nxt;
        end
    end

    assign db_level     = db_level_q;
    assign press_tick   = press_tick_q;
    assign release_tick = release_tick_q;
    assign press_any    = press_any_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (NCH=4, N=4, SYNC_STAGES=2): expected tick events are
// queued when stimulus is driven and popped when the DUT reaches that cycle.
module tb_debounce_multi;

    localparam int unsigned NCH  = 4;
    localparam int unsigned N    = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned RD   = 8;
    localparam int unsigned RP   = 4;
    localparam int          LAT  = int'(SYNC) + (1 << N);
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] btn = '0;
    logic [NCH-1:0] db_level;
    logic [NCH-1:0] press_tick;
    logic [NCH-1:0] release_tick;
    logic           press_any;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] prs;
        logic [NCH-1:0] rel;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;

    debounce_multi #(
        .NCH          (NCH),
        .N            (N),
        .SYNC_STAGES  (SYNC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk_100MHz  (clk),
        .reset       (rst),
        .btn         (btn),
        .db_level    (db_level),
        .press_tick  (press_tick),
        .release_tick(release_tick),
        .press_any   (press_any)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Keep the queue sorted by cycle; events in the same cycle merge into one entry.
    task automatic push_ev(input int c, input logic [NCH-1:0] p, input logic [NCH-1:0] r);
        int  i;
        ev_t e;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc < c) i++;
        if (i < exp_q.size() && exp_q[i].cyc == c) begin
            e     = exp_q[i];
            e.prs = e.prs | p;
            e.rel = e.rel | r;
            exp_q[i] = e;
        end else begin
            e.cyc = c;
            e.prs = p;
            e.rel = r;
            exp_q.insert(i, e);
        end
    endtask

    // Auto-repeat ticks at h0+RD, then every RP, while the cycle before lies in the HIGH run.
    task automatic push_repeat(input int ch, input int h0, input int last_high);
        int             c;
        logic [NCH-1:0] m;
        m = NCH'(1) << ch;
        if (RPT_ON) begin
            c = h0 + int'(RD);
            while (c <= last_high + 1) begin
                push_ev(c, m, '0);
                c += int'(RP);
            end
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            mon_ev = exp_q.pop_front();
            check("missed_event_cycle", 32'(cyc), 32'(mon_ev.cyc));
        end
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            mon_ev = exp_q.pop_front();
            check("press_tick", 32'(press_tick), 32'(mon_ev.prs));
            check("release_tick", 32'(release_tick), 32'(mon_ev.rel));
            check("press_any", 32'(press_any), 32'(|mon_ev.prs));
        end else if (press_tick != '0 || release_tick != '0 || press_any) begin
            check("spurious_tick", 32'({press_tick, release_tick, press_any}), 32'h0);
        end
    end

    initial begin
        logic [4:0] bounce;
        bounce = 5'b01010;

        wait_cyc(1);
        check("rst_db_level", 32'(db_level), 32'h0);
        check("rst_press_tick", 32'(press_tick), 32'h0);
        check("rst_release_tick", 32'(release_tick), 32'h0);
        wait_cyc(2);
        rst = 1'b0;

        // Clean press and release on channel 0
        wait_cyc(10);
        btn[0] = 1'b1;
        push_ev(10 + LAT, 4'b0001, '0);
        push_repeat(0, 10 + LAT, 62);
        wait_cyc(27);
        check("db_before_press", 32'(db_level), 32'h0);
        wait_cyc(28);
        check("db_at_press", 32'(db_level), 32'h1);
        wait_cyc(60);
        btn[0] = 1'b0;
        push_ev(60 + LAT, '0, 4'b0001);
        wait_cyc(77);
        check("db_before_release", 32'(db_level), 32'h1);
        wait_cyc(78);
        check("db_at_release", 32'(db_level), 32'h0);

        // Glitches of 10 and 15 cycles are filtered; 16 cycles is the shortest accepted press
        wait_cyc(80);
        btn[1] = 1'b1;
        wait_cyc(90);
        btn[1] = 1'b0;
        wait_cyc(105);
        check("db_glitch10", 32'(db_level), 32'h0);
        wait_cyc(110);
        btn[1] = 1'b1;
        wait_cyc(125);
        btn[1] = 1'b0;
        wait_cyc(145);
        check("db_glitch15", 32'(db_level), 32'h0);
        wait_cyc(150);
        btn[1] = 1'b1;
        push_ev(150 + LAT, 4'b0010, '0);
        push_repeat(1, 150 + LAT, 150 + LAT);
        wait_cyc(166);
        btn[1] = 1'b0;
        push_ev(166 + LAT, '0, 4'b0010);
        wait_cyc(168);
        check("db_pulse16", 32'(db_level), 32'h2);
        wait_cyc(183);
        check("db_pulse16_hold", 32'(db_level), 32'h2);
        wait_cyc(184);
        check("db_pulse16_end", 32'(db_level), 32'h0);

        // Simultaneous press on channels 2 and 3; channel 3 releases with bounce
        wait_cyc(200);
        btn[3:2] = 2'b11;
        push_ev(200 + LAT, 4'b1100, '0);
        push_repeat(2, 200 + LAT, 242);
        push_repeat(3, 200 + LAT, 250);
        wait_cyc(217);
        check("db_before_dual", 32'(db_level), 32'h0);
        wait_cyc(218);
        check("db_dual", 32'(db_level), 32'hc);
        wait_cyc(240);
        btn[2] = 1'b0;
        push_ev(240 + LAT, '0, 4'b0100);
        for (int k = 0; k < 5; k++) begin
            wait_cyc(248 + k);
            btn[3] = bounce[k];
        end
        push_ev(252 + LAT, '0, 4'b1000);
        wait_cyc(269);
        check("db_bounce_hold", 32'(db_level), 32'h8);
        wait_cyc(270);
        check("db_bounce_end", 32'(db_level), 32'h0);

        // Reset in the middle of WAIT_H, button held through deassertion
        wait_cyc(300);
        btn[0] = 1'b1;
        wait_cyc(305);
        rst = 1'b1;
        wait_cyc(307);
        check("db_in_reset", 32'(db_level), 32'h0);
        check("press_in_reset", 32'(press_tick), 32'h0);
        wait_cyc(310);
        rst = 1'b0;
        push_ev(310 + LAT, 4'b0001, '0);
        push_repeat(0, 310 + LAT, 362);
        wait_cyc(327);
        check("db_after_reset_pre", 32'(db_level), 32'h0);
        wait_cyc(328);
        check("db_after_reset", 32'(db_level), 32'h1);
        wait_cyc(360);
        btn[0] = 1'b0;
        push_ev(360 + LAT, '0, 4'b0001);

        wait_cyc(400);
        check("events_outstanding", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
